// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down counter with IDLE/RUN/DONE control and terminal-count pulse.
// Define DOWN_COUNTER_TIMER_RELOAD_EN to enable periodic auto-reload through the periodic port.
module down_counter_timer #(
  parameter int nBits = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [nBits-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             periodic,
  output logic [nBits-1:0] counter,
  output logic             tc,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [nBits-1:0] reload;
  logic auto_reload;
`ifdef DOWN_COUNTER_TIMER_RELOAD_EN
  assign auto_reload = periodic && reload != '0;
`else
  logic unused_periodic;
  assign unused_periodic = periodic;
  assign auto_reload = 1'b0;
`endif
  assign busy = state == RUN;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      counter <= '0;
      reload  <= '0;
      tc      <= 1'b0;
    end else if (load) begin
      state   <= IDLE;
      counter <= load_value;
      reload  <= load_value;
      tc      <= 1'b0;
    end else begin
      tc <= 1'b0;
      case (state)
        RUN:
          if (stop) state <= IDLE;
          else if (en && counter > 1) counter <= counter - 1'b1;
          else if (en && counter != '0) begin
            tc      <= 1'b1;
            counter <= auto_reload ? reload : '0;
            state   <= auto_reload ? RUN : DONE;
          end
        IDLE:
          if (start) begin
            state <= counter != '0 ? RUN : DONE;
            tc    <= counter == '0;
          end
        default:
          if (start) begin
            counter <= reload;
            state   <= reload != '0 ? RUN : DONE;
            tc      <= reload == '0;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer: directed checks of down_counter_timer at nBits=4.
module tb_down_counter_timer;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0, start = 1'b0, stop = 1'b0, en = 1'b0, periodic = 1'b0;
  logic [3:0] load_value = '0;
  logic [3:0] counter;
  logic tc, busy, done;
  int errors = 0, checks = 0;
  down_counter_timer #(.nBits(4)) dut (
    .clk(clk), .rst(rst), .load(load), .load_value(load_value), .start(start),
    .stop(stop), .en(en), .periodic(periodic), .counter(counter), .tc(tc),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [3:0] c, input logic t, input logic b, input logic d);
    checks++;
    assert ({counter, tc, busy, done} === {c, t, b, d})
    else begin
      errors++;
      $error("FAIL %s: got counter=%0d tc=%b busy=%b done=%b, expected counter=%0d tc=%b busy=%b done=%b",
             tag, counter, tc, busy, done, c, t, b, d);
    end
  endtask
  initial begin
    load = 1'b1; start = 1'b1; load_value = 4'd9;
    cyc(); chk("reset", 0, 0, 0, 0);
    rst = 1'b0; load = 1'b0; start = 1'b0;
    load_value = 4'd3; load = 1'b1; cyc(); load = 1'b0; chk("load3", 3, 0, 0, 0);
    start = 1'b1; cyc(); start = 1'b0; chk("start3", 3, 0, 1, 0);
    en = 1'b1;
    cyc(); chk("run3_2", 2, 0, 1, 0);
    cyc(); chk("run3_1", 1, 0, 1, 0);
    cyc(); chk("run3_tc", 0, 1, 0, 1);
    cyc(); chk("done_hold", 0, 0, 0, 1);
    en = 1'b0;
    start = 1'b1; cyc(); start = 1'b0; chk("restart_done", 3, 0, 1, 0);
    stop = 1'b1; cyc(); stop = 1'b0; chk("stop_run", 3, 0, 0, 0);
    load_value = 4'd5; load = 1'b1; cyc(); load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0; chk("start5", 5, 0, 1, 0);
    for (int i = 0; i < 9; i++) begin
      en = (i % 2 == 0);
      cyc();
      if (i == 3) chk("toggle_3", 3, 0, 1, 0);
      if (i == 7) chk("toggle_1", 1, 0, 1, 0);
    end
    en = 1'b0; chk("toggle_tc", 0, 1, 0, 1);
    load_value = 4'd9; load = 1'b1; cyc(); load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    en = 1'b1; repeat (4) cyc(); en = 1'b0; chk("run9_5", 5, 0, 1, 0);
    stop = 1'b1; cyc(); stop = 1'b0; chk("stop9", 5, 0, 0, 0);
    en = 1'b1; cyc(); chk("idle_en", 5, 0, 0, 0);
    en = 1'b0; start = 1'b1; cyc(); start = 1'b0; chk("resume", 5, 0, 1, 0);
    en = 1'b1; cyc(); chk("resume_4", 4, 0, 1, 0);
    cyc(); en = 1'b0; chk("resume_3", 3, 0, 1, 0);
    load_value = 4'd2; load = 1'b1; cyc(); load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    en = 1'b1; cyc(); chk("run2_1", 1, 0, 1, 0);
    load_value = 4'd7; load = 1'b1; cyc(); load = 1'b0; en = 1'b0; chk("load_over_tc", 7, 0, 0, 0);
    start = 1'b1; cyc(); chk("start7", 7, 0, 1, 0);
    en = 1'b1; cyc(); start = 1'b0; en = 1'b0; chk("start_in_run", 6, 0, 1, 0);
    periodic = 1'b1;
    load_value = 4'd3; load = 1'b1; cyc(); load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0; en = 1'b1;
`ifdef DOWN_COUNTER_TIMER_RELOAD_EN
    for (int i = 0; i < 9; i++) begin
      cyc();
      chk("periodic", ((i + 1) % 3 == 0) ? 4'd3 : 4'(3 - (i + 1) % 3), (i + 1) % 3 == 0, 1, 0);
    end
`else
    cyc(); chk("nonper_2", 2, 0, 1, 0);
    cyc(); chk("nonper_1", 1, 0, 1, 0);
    cyc(); chk("nonper_tc", 0, 1, 0, 1);
`endif
    en = 1'b0; periodic = 1'b0;
    load_value = 4'd0; load = 1'b1; cyc(); load = 1'b0; chk("load0", 0, 0, 0, 0);
    start = 1'b1; cyc(); start = 1'b0; chk("start0_tc", 0, 1, 0, 1);
    cyc(); chk("start0_hold", 0, 0, 0, 1);
    start = 1'b1; cyc(); start = 1'b0; chk("done_reload0", 0, 1, 0, 1);
    load_value = 4'd6; load = 1'b1; cyc(); load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    en = 1'b1; repeat (2) cyc(); chk("run6_4", 4, 0, 1, 0);
    rst = 1'b1; load = 1'b1; start = 1'b1; load_value = 4'd8; cyc();
    chk("rst_mid_run", 0, 0, 0, 0);
    rst = 1'b0; load = 1'b0; start = 1'b0; cyc(); chk("after_rst", 0, 0, 0, 0);
    en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
